// File: rtl/spi_tx_feeder_pkg.sv
// Shared state encoding and bus-width default for the SPI TX feeder.
package spi_tx_feeder_pkg;

  localparam int DEFAULT_DATAWIDTH_BUS = 8;
  localparam int STATE_SIZE            = 3;

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    CAPTURE   = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/spi_tx_feeder_if.sv
// Host-side and SPI-master-side signals of the TX feeder. The slave modport is the
// feeder itself; the master modport is whatever drives it (host plus SPI master).
interface spi_tx_feeder_if
  import spi_tx_feeder_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEFAULT_DATAWIDTH_BUS
);
  logic                     SPI_TX_FEEDER_wr_InHigh;
  logic [DATAWIDTH_BUS-1:0] SPI_TX_FEEDER_data_In;
  logic                     SPI_TX_FEEDER_full_Out;
  logic                     SPI_TX_FEEDER_empty_Out;
  logic                     SPI_TX_FEEDER_idle_Out;
  logic [DATAWIDTH_BUS-1:0] SPI_TX_FEEDER_rxData_Out;
  logic                     SPI_TX_FEEDER_rxValid_Out;
  logic                     SPI_TX_FEEDER_start_OutHigh;
  logic [DATAWIDTH_BUS-1:0] SPI_TX_FEEDER_data_Out;
  logic                     SPI_TX_FEEDER_busy_In;
  logic                     SPI_TX_FEEDER_newData_In;
  logic [DATAWIDTH_BUS-1:0] SPI_TX_FEEDER_masterData_In;
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
  logic                     SPI_TX_FEEDER_timeout_Out;
`endif

  modport slave (
    input  SPI_TX_FEEDER_wr_InHigh, SPI_TX_FEEDER_data_In, SPI_TX_FEEDER_busy_In,
           SPI_TX_FEEDER_newData_In, SPI_TX_FEEDER_masterData_In,
    output SPI_TX_FEEDER_full_Out, SPI_TX_FEEDER_empty_Out, SPI_TX_FEEDER_idle_Out,
           SPI_TX_FEEDER_rxData_Out, SPI_TX_FEEDER_rxValid_Out,
           SPI_TX_FEEDER_start_OutHigh, SPI_TX_FEEDER_data_Out
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    , output SPI_TX_FEEDER_timeout_Out
`endif
  );

  modport master (
    output SPI_TX_FEEDER_wr_InHigh, SPI_TX_FEEDER_data_In, SPI_TX_FEEDER_busy_In,
           SPI_TX_FEEDER_newData_In, SPI_TX_FEEDER_masterData_In,
    input  SPI_TX_FEEDER_full_Out, SPI_TX_FEEDER_empty_Out, SPI_TX_FEEDER_idle_Out,
           SPI_TX_FEEDER_rxData_Out, SPI_TX_FEEDER_rxValid_Out,
           SPI_TX_FEEDER_start_OutHigh, SPI_TX_FEEDER_data_Out
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    , input SPI_TX_FEEDER_timeout_Out
`endif
  );

endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags derived from the next-state count.
// A write into a full FIFO is accepted only when a pop happens on the same edge.
module spi_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_en, rd_en;

  assign rd_en   = rd && !empty;
  assign wr_en   = wr && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    // NOTE: assign the default before the case so uncovered encodings cannot infer a latch.
    count_next = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: ;
    endcase
  end

  // NOTE: storage is intentionally not reset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (ADDR_WIDTH+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Buffers host bytes and runs one SPI master transfer per byte, returning each RX byte.
// Optional watchdog on the master handshake: define SPI_TX_FEEDER_TIMEOUT_EN.
module spi_tx_feeder
  import spi_tx_feeder_pkg::*;
#(
  parameter int DATAWIDTH_BUS   = DEFAULT_DATAWIDTH_BUS,
  parameter int FIFO_ADDR_WIDTH = 2
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
  input logic            SPI_TX_FEEDER_CLOCK_50,
  input logic            SPI_TX_FEEDER_RESET_InLow,
  spi_tx_feeder_if.slave bus
);
  logic clk, rst_n;
  assign clk   = SPI_TX_FEEDER_CLOCK_50;
  assign rst_n = SPI_TX_FEEDER_RESET_InLow;

  feeder_state_t            state;
  logic [DATAWIDTH_BUS-1:0] fifo_head, tx_data, rx_data;
  logic [FIFO_ADDR_WIDTH:0] fifo_count;
  logic                     fifo_full, fifo_empty, pop, start, rx_valid;

  // A new byte is launched only when the master reports itself free.
  assign pop = (state == IDLE) && !fifo_empty && !bus.SPI_TX_FEEDER_busy_In;

  spi_tx_fifo #(
    .WIDTH      (DATAWIDTH_BUS),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (bus.SPI_TX_FEEDER_wr_InHigh),
    .wr_data (bus.SPI_TX_FEEDER_data_In),
    .rd      (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef SPI_TX_FEEDER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog;
  logic              timeout, wdog_expired;
  assign wdog_expired                  = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign bus.SPI_TX_FEEDER_timeout_Out = timeout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_data  <= '0;
      rx_data  <= '0;
      start    <= 1'b0;
      rx_valid <= 1'b0;
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
      wdog     <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      start    <= 1'b0;
      rx_valid <= 1'b0;
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
      wdog     <= '0;
      timeout  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= fifo_head;
            state   <= LOAD;
          end
        end
        LOAD: begin
          start <= 1'b1;
          state <= START;
        end
        START: state <= WAIT_BUSY;
        WAIT_BUSY, WAIT_DONE: begin
          // A master that finishes without ever showing busy is still honoured.
          if (bus.SPI_TX_FEEDER_newData_In) begin
            rx_data  <= bus.SPI_TX_FEEDER_masterData_In;
            rx_valid <= 1'b1;
            state    <= CAPTURE;
          end else if (state == WAIT_BUSY && bus.SPI_TX_FEEDER_busy_In) begin
            state <= WAIT_DONE;
          end
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
          else if (wdog_expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SPI_TX_FEEDER_full_Out      = fifo_full;
  assign bus.SPI_TX_FEEDER_empty_Out     = fifo_empty;
  assign bus.SPI_TX_FEEDER_idle_Out      = (state == IDLE) && (fifo_count == '0);
  assign bus.SPI_TX_FEEDER_start_OutHigh = start;
  assign bus.SPI_TX_FEEDER_data_Out      = tx_data;
  assign bus.SPI_TX_FEEDER_rxData_Out    = rx_data;
  assign bus.SPI_TX_FEEDER_rxValid_Out   = rx_valid;

endmodule
